// File: rtl/sc_reg_level_ctrl.sv
// sc_reg_level_ctrl: obstacle pattern register that steps on time-base ticks, with a game level that
// shortens the step period and advances automatically or on a manual request.
module sc_reg_level_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int LEVEL_WIDTH = 3,
    parameter int MAX_LEVEL = 5,
    parameter bit LEVEL_WRAP = 1'b0,
    parameter int BASE_PERIOD = 4,
    parameter int PERIOD_STEP = 1,
    parameter int TICKS_PER_LEVEL = 16,
    parameter logic [DATAWIDTH-1:0] INIT_PATTERN = 8'h01
) (
    input  logic                   SC_RegLEVEL_CLOCK_50,
    input  logic                   SC_RegLEVEL_RESET_InHigh,
    input  logic                   SC_RegLEVEL_clear_InLow,
    input  logic                   SC_RegLEVEL_load_InLow,
    input  logic [DATAWIDTH-1:0]   SC_RegLEVEL_data_InBUS,
    input  logic [1:0]             SC_RegLEVEL_mode_InBUS,
    input  logic                   SC_RegLEVEL_serial_In,
    input  logic                   SC_RegLEVEL_tick_In,
    input  logic                   SC_RegLEVEL_levelUp_InLow,
    output logic [DATAWIDTH-1:0]   SC_RegLEVEL_data_OutBUS,
    output logic [LEVEL_WIDTH-1:0] SC_RegLEVEL_level_OutBUS,
    output logic                   SC_RegLEVEL_levelChange_Out,
    output logic                   SC_RegLEVEL_maxLevel_Out
);
    localparam int SW = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
    localparam int LW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    logic [SW-1:0] stepCnt;
    logic [SW-1:0] periodM1;
    logic [LW-1:0] lvlCnt;
    logic levelUpPrev;
    logic [DATAWIDTH-1:0] stepped;
    logic [LEVEL_WIDTH-1:0] nextLevel;
    logic stepHit;
    logic lvlWrap;
    logic levelAdv;
    int levelStep;

    always_comb begin
        levelStep = int'(SC_RegLEVEL_level_OutBUS) * PERIOD_STEP;
        // period-1 clamps at zero: compare first so the subtraction never underflows
        periodM1 = (levelStep >= BASE_PERIOD - 1) ? '0 : SW'(BASE_PERIOD - 1 - levelStep);
        stepHit = SC_RegLEVEL_tick_In && stepCnt == periodM1;
        lvlWrap = SC_RegLEVEL_tick_In && lvlCnt == LW'(TICKS_PER_LEVEL - 1);
        levelAdv = (lvlWrap || (levelUpPrev && !SC_RegLEVEL_levelUp_InLow)) &&
                   (SC_RegLEVEL_level_OutBUS != LEVEL_WIDTH'(MAX_LEVEL) || LEVEL_WRAP);
        nextLevel = (SC_RegLEVEL_level_OutBUS == LEVEL_WIDTH'(MAX_LEVEL)) ? '0 : SC_RegLEVEL_level_OutBUS + 1'b1;
        stepped = (SC_RegLEVEL_mode_InBUS == 2'b01) ? {SC_RegLEVEL_data_OutBUS[DATAWIDTH-2:0], SC_RegLEVEL_data_OutBUS[DATAWIDTH-1]} :
                  (SC_RegLEVEL_mode_InBUS == 2'b10) ? {SC_RegLEVEL_data_OutBUS[0], SC_RegLEVEL_data_OutBUS[DATAWIDTH-1:1]} :
                  (SC_RegLEVEL_mode_InBUS == 2'b11) ? {SC_RegLEVEL_data_OutBUS[DATAWIDTH-2:0], SC_RegLEVEL_serial_In} :
                  SC_RegLEVEL_data_OutBUS;
    end

    assign SC_RegLEVEL_maxLevel_Out = SC_RegLEVEL_level_OutBUS == LEVEL_WIDTH'(MAX_LEVEL);

    always_ff @(posedge SC_RegLEVEL_CLOCK_50) begin
        if (SC_RegLEVEL_RESET_InHigh) begin
            SC_RegLEVEL_data_OutBUS <= INIT_PATTERN;
            SC_RegLEVEL_level_OutBUS <= '0;
            SC_RegLEVEL_levelChange_Out <= 1'b0;
            stepCnt <= '0;
            lvlCnt <= '0;
            levelUpPrev <= 1'b1;
        end else begin
            levelUpPrev <= SC_RegLEVEL_levelUp_InLow;
            if (!SC_RegLEVEL_clear_InLow) begin
                SC_RegLEVEL_data_OutBUS <= INIT_PATTERN;
                SC_RegLEVEL_level_OutBUS <= '0;
                SC_RegLEVEL_levelChange_Out <= 1'b0;
                stepCnt <= '0;
                lvlCnt <= '0;
            end else begin
                SC_RegLEVEL_levelChange_Out <= levelAdv;
                if (levelAdv)
                    SC_RegLEVEL_level_OutBUS <= nextLevel;
                if (SC_RegLEVEL_tick_In)
                    lvlCnt <= lvlWrap ? '0 : lvlCnt + 1'b1;
                if (!SC_RegLEVEL_load_InLow) begin
                    SC_RegLEVEL_data_OutBUS <= SC_RegLEVEL_data_InBUS;
                    stepCnt <= '0;
                end else if (SC_RegLEVEL_tick_In) begin
                    stepCnt <= stepHit ? '0 : stepCnt + 1'b1;
                    if (stepHit)
                        SC_RegLEVEL_data_OutBUS <= stepped;
                end
                // a level change restarts the step count so the new period starts cleanly
                if (levelAdv)
                    stepCnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sc_reg_level_ctrl.sv
// tb_sc_reg_level_ctrl: directed stimulus with a scoreboard queue; one saturating and one wrapping
// instance share all inputs.
module tb_sc_reg_level_ctrl;
    logic clk = 1'b0;
    logic rst, clr, ld, ser, tick, up;
    logic [7:0] data;
    logic [1:0] mode;
    logic [7:0] d0, d1;
    logic [2:0] l0, l1;
    logic c0, c1, m0, m1;
    logic [13:0] expQ[$];
    string nameQ[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_reg_level_ctrl #(.LEVEL_WRAP(1'b0)) dutSat (
        .SC_RegLEVEL_CLOCK_50(clk), .SC_RegLEVEL_RESET_InHigh(rst), .SC_RegLEVEL_clear_InLow(clr),
        .SC_RegLEVEL_load_InLow(ld), .SC_RegLEVEL_data_InBUS(data), .SC_RegLEVEL_mode_InBUS(mode),
        .SC_RegLEVEL_serial_In(ser), .SC_RegLEVEL_tick_In(tick), .SC_RegLEVEL_levelUp_InLow(up),
        .SC_RegLEVEL_data_OutBUS(d0), .SC_RegLEVEL_level_OutBUS(l0),
        .SC_RegLEVEL_levelChange_Out(c0), .SC_RegLEVEL_maxLevel_Out(m0));

    sc_reg_level_ctrl #(.LEVEL_WRAP(1'b1)) dutWrap (
        .SC_RegLEVEL_CLOCK_50(clk), .SC_RegLEVEL_RESET_InHigh(rst), .SC_RegLEVEL_clear_InLow(clr),
        .SC_RegLEVEL_load_InLow(ld), .SC_RegLEVEL_data_InBUS(data), .SC_RegLEVEL_mode_InBUS(mode),
        .SC_RegLEVEL_serial_In(ser), .SC_RegLEVEL_tick_In(tick), .SC_RegLEVEL_levelUp_InLow(up),
        .SC_RegLEVEL_data_OutBUS(d1), .SC_RegLEVEL_level_OutBUS(l1),
        .SC_RegLEVEL_levelChange_Out(c1), .SC_RegLEVEL_maxLevel_Out(m1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expectation of the registered state just produced: {instance, data, level, levelChange, maxLevel}
    task automatic chk(input string n, input bit s, input logic [7:0] d, input logic [2:0] l, input logic c);
        expQ.push_back({s, d, l, c, l == 3'd5});
        nameQ.push_back(n);
    endtask

    initial begin
        logic [13:0] e, act;
        string n;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                act = e[13] ? {1'b1, d1, l1, c1, m1} : {1'b0, d0, l0, c0, m0};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got data=%h level=%0d change=%b max=%b, expected data=%h level=%0d change=%b max=%b",
                             n, act[12:5], act[4:2], act[1], act[0], e[12:5], e[4:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst = 1; clr = 1; ld = 1; ser = 0; tick = 0; up = 1; data = 0; mode = 0;
        step(); rst = 0;
        chk("reset", 0, 8'h01, 0, 0);
        mode = 2'b01; tick = 1;
        repeat (3) step(); chk("rotl_hold3", 0, 8'h01, 0, 0);
        step(); chk("rotl_step4", 0, 8'h02, 0, 0);
        repeat (4) step(); chk("rotl_step8", 0, 8'h04, 0, 0);
        tick = 0; ld = 0; data = 8'h81; mode = 2'b10;
        step(); ld = 1; chk("load", 0, 8'h81, 0, 0);
        tick = 1;
        repeat (3) step(); chk("rotr_hold", 0, 8'h81, 0, 0);
        step(); chk("rotr_step", 0, 8'hC0, 0, 0);
        mode = 2'b11; ser = 1;
        repeat (3) step(); chk("shl_hold", 0, 8'hC0, 0, 0);
        step(); chk("shl_step_auto_lvl1", 0, 8'h81, 1, 1);
        tick = 0;
        step(); chk("pulse_one_cycle", 0, 8'h81, 1, 0);
        mode = 2'b01; tick = 1;
        repeat (2) step(); chk("period3_hold", 0, 8'h81, 1, 0);
        step(); chk("period3_step", 0, 8'h03, 1, 0);
        tick = 0; up = 0;
        step(); chk("manual_inc", 0, 8'h03, 2, 1);
        step(); chk("manual_held", 0, 8'h03, 2, 0);
        repeat (8) step(); chk("manual_once", 0, 8'h03, 2, 0);
        up = 1; step();
        mode = 2'b00; tick = 1;
        repeat (12) step(); chk("mode00_hold", 0, 8'h03, 2, 0);
        up = 0;
        step(); up = 1; tick = 0; chk("merged_inc", 0, 8'h03, 3, 1);
        step(); chk("merged_once", 0, 8'h03, 3, 0);
        up = 0; step(); up = 1; chk("to_level4", 0, 8'h03, 4, 1);
        step();
        up = 0; step(); up = 1; chk("to_level5", 0, 8'h03, 5, 1);
        step(); chk("max_level", 0, 8'h03, 5, 0);
        mode = 2'b01; tick = 1;
        step(); chk("period1_a", 0, 8'h06, 5, 0);
        step(); chk("period1_b", 0, 8'h0C, 5, 0);
        tick = 0; up = 0;
        step(); up = 1;
        chk("saturate_no_pulse", 0, 8'h0C, 5, 0);
        chk("wrap_to_zero", 1, 8'h0C, 0, 1);
        step(); chk("saturate_after", 0, 8'h0C, 5, 0);
        rst = 1; step(); rst = 0;
        repeat (3) begin
            up = 0; step(); up = 1; step();
        end
        chk("level3", 0, 8'h01, 3, 0);
        tick = 1;
        repeat (2) step(); chk("level3_ticks", 0, 8'h04, 3, 0);
        clr = 0; step(); clr = 1;
        chk("clear_on_tick", 0, 8'h01, 0, 0);
        repeat (3) step(); chk("clear_stepcnt_hold", 0, 8'h01, 0, 0);
        step(); chk("clear_stepcnt_step", 0, 8'h02, 0, 0);
        repeat (11) step(); chk("clear_lvlcnt_15", 0, 8'h08, 0, 0);
        step(); chk("clear_lvlcnt_16", 0, 8'h10, 1, 1);
        repeat (2) step(); chk("before_reset", 0, 8'h10, 1, 0);
        rst = 1; step(); rst = 0; tick = 0;
        chk("reset_on_step", 0, 8'h01, 0, 0);
        step();
        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
